// File: rtl/eth_stats_snapshot_buffer.sv
// eth_stats_snapshot_buffer
//   Samples NUM_CHANNELS counters plus a 64-bit timestamp whenever a sample
//   event fires and queues each snapshot in a DEPTH-entry circular buffer.
//   Software pops the snapshots in order through a first-word-fall-through port.
//   Sample events can come from three sources:
//     - on-change: the counters differ from the previous cycle's counters
//     - periodic:  a tick every sample_period cycles
//     - manual:    a one-cycle request
//   Every event consumes a sequence number, including events that are later
//   lost, so software can see gaps.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   enable           sampling active
//   trigger_mask     [0] on-change, [1] periodic
//   sample_period    periodic interval in cycles (0 = periodic off)
//   manual_trigger   one-cycle sample request
//   overwrite        full policy: 1 = overwrite oldest, 0 = drop new
//   flush            one-cycle buffer clear
//   current_time     timestamp captured with each snapshot
//   stats_in         channel counters, channel 0 in the LSBs
//   out_valid        head entry available
//   out_ready        pop the head entry
//   out_time         head timestamp (0 when empty)
//   out_stats        head counters (0 when empty)
//   out_seq          head sequence number (0 when empty)
//   occupancy        number of stored entries, 0..DEPTH
//   dropped_count    snapshots lost, saturating
module eth_stats_snapshot_buffer #(
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_WIDTH    = 64,
  parameter int DEPTH        = 16,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [1:0]                        trigger_mask,
  input  logic [PERIOD_WIDTH-1:0]           sample_period,
  input  logic                              manual_trigger,
  input  logic                              overwrite,
  input  logic                              flush,
  input  logic [63:0]                       current_time,
  input  logic [NUM_CHANNELS*CNT_WIDTH-1:0] stats_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [63:0]                       out_time,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] out_stats,
  output logic [31:0]                       out_seq,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic [31:0]                       dropped_count
);

  localparam int SW = NUM_CHANNELS * CNT_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Control state
  logic [SW-1:0]           prev_stats_q;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [31:0]             seq_q, seq_d;
  logic [31:0]             drop_q, drop_d;

  // Snapshot storage (data only, never reset)
  logic [63:0]   time_mem  [DEPTH];
  logic [SW-1:0] stats_mem [DEPTH];
  logic [31:0]   seq_mem   [DEPTH];

  logic period_run, tick, change, evt, evt_live;
  logic full, empty, pop, wr_en, drop, rd_adv;

  // Event detection
  assign period_run = enable & trigger_mask[1] & (sample_period != '0);
  // >= rather than == so that shrinking the period below the current count
  // still ticks on the next cycle instead of waiting for a wrap.
  assign tick       = period_run & (period_cnt_q >= (sample_period - PERIOD_WIDTH'(1)));
  assign change     = (stats_in != prev_stats_q);
  assign evt        = enable & ((trigger_mask[0] & change) | tick | manual_trigger);
  // An event coinciding with flush is discarded entirely: it consumes no
  // sequence number and is not counted as dropped.
  assign evt_live   = evt & ~flush;

  // Buffer bookkeeping
  assign full   = (occ_q == OW'(DEPTH));
  assign empty  = (occ_q == '0);
  assign pop    = ~empty & out_ready;
  // A full buffer still accepts the write when a pop frees a slot this cycle
  // or when overwrite mode evicts the oldest entry.
  assign wr_en  = evt_live & (~full | pop | overwrite);
  assign drop   = evt_live & full & ~pop;
  // Overwrite eviction advances the read pointer just like a pop.
  assign rd_adv = pop | (wr_en & full & ~pop);

  always_comb begin
    period_cnt_d = period_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    seq_d        = seq_q;
    drop_d       = drop_q;

    if (!period_run || tick) begin
      period_cnt_d = '0;
    end else begin
      period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(rd_adv);
      occ_d    = occ_q + OW'(wr_en) - OW'(rd_adv);
    end

    if (evt_live) begin
      seq_d = seq_q + 32'd1;
    end

    if (drop) begin
      drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_stats_q <= '0;
      period_cnt_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      seq_q        <= '0;
      drop_q       <= '0;
    end else begin
      prev_stats_q <= stats_in;
      period_cnt_q <= period_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      seq_q        <= seq_d;
      drop_q       <= drop_d;
    end
  end

  // Capture stage: snapshot of this cycle lands at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      time_mem[wr_ptr_q]  <= current_time;
      stats_mem[wr_ptr_q] <= stats_in;
      seq_mem[wr_ptr_q]   <= seq_q;
    end
  end

  // Fall-through head view, forced to zero while empty
  assign out_valid     = ~empty;
  assign out_time      = empty ? '0 : time_mem[rd_ptr_q];
  assign out_stats     = empty ? '0 : stats_mem[rd_ptr_q];
  assign out_seq       = empty ? '0 : seq_mem[rd_ptr_q];
  assign occupancy     = occ_q;
  assign dropped_count = drop_q;

endmodule
